// File: rtl/riscy_pkg.sv
// Shared control-flow types for the execute-stage branch resolver and its
// branch history table.
package riscy_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_op_e;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_INIT = 2'b01;

  // Saturating 2-bit counter step; the MSB of the counter is the prediction.
  function automatic bht_ctr_t bht_next(bht_ctr_t c, logic tkn);
    bht_ctr_t n;
    n = c;
    if (tkn) begin
      if (c != 2'b11) n = c + 2'b01;
    end else begin
      if (c != 2'b00) n = c - 2'b01;
    end
    return n;
  endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module bht
  import riscy_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_tkn,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_tkn
);

  bht_ctr_t ctr [ENTRIES];

  // No read bypass: a same-cycle update is only visible on the next read.
  assign rd_tkn = ctr[rd_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= BHT_INIT;
      end
    end else if (upd_en) begin
      ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_tkn);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage resolver for RV32I branches and jumps: condition, target,
// link, mispredict and redirect, held in one valid/ready result stage.
module branch_resolve_unit
  import riscy_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  br_op_e          in_op,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_tkn,
  input  logic [XLEN-1:0] in_pred_tgt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic [XLEN-1:0] out_redirect,
  output logic            out_mispred,
  output logic            out_illegal,
  output logic            out_misalign,
  input  logic [XLEN-1:0] bht_rd_pc,
  output logic            bht_rd_tkn
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0]  sum_pc_imm;
  logic [XLEN-1:0]  sum_rs1_imm;
  logic [XLEN-1:0]  c_link;
  logic [XLEN-1:0]  c_target;
  logic [XLEN-1:0]  c_redirect;
  logic             c_cond_tkn;
  logic             c_cond_illegal;
  logic             c_taken;
  logic             c_illegal;
  logic             c_mispred;
  logic             c_misalign;
  logic             c_trains;
  logic             load;
  logic [IDX_W-1:0] r_idx;
  logic             r_trains;
  logic             bht_upd_en;
  logic             unused_rd_pc_bits;

  assign in_ready = !out_valid || out_ready;
  // Only real ops occupy the result stage; an accepted bubble just drains it.
  assign load     = in_valid && in_ready && !flush && (in_op != BR_NONE);

  assign sum_pc_imm  = in_pc + in_imm;
  assign sum_rs1_imm = in_rs1 + in_imm;
  assign c_link      = in_pc + {{(XLEN-3){1'b0}}, 3'd4};

  always_comb begin
    c_cond_tkn     = 1'b0;
    c_cond_illegal = 1'b0;
    case (in_funct3)
      F3_BEQ:  c_cond_tkn = (in_rs1 == in_rs2);
      F3_BNE:  c_cond_tkn = (in_rs1 != in_rs2);
      F3_BLT:  c_cond_tkn = ($signed(in_rs1) <  $signed(in_rs2));
      F3_BGE:  c_cond_tkn = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: c_cond_tkn = (in_rs1 <  in_rs2);
      F3_BGEU: c_cond_tkn = (in_rs1 >= in_rs2);
      default: c_cond_illegal = 1'b1;
    endcase
  end

  // Illegal conditional encodings resolve as not-taken and never redirect fetch.
  always_comb begin
    c_taken   = 1'b0;
    c_illegal = 1'b0;
    c_target  = sum_pc_imm;
    c_mispred = 1'b0;
    c_trains  = 1'b0;
    case (in_op)
      BR_COND: begin
        c_illegal = c_cond_illegal;
        c_taken   = c_cond_tkn && !c_cond_illegal;
        c_trains  = !c_cond_illegal;
        c_mispred = !c_cond_illegal &&
                    ((c_taken != in_pred_tkn) ||
                     (c_taken && in_pred_tkn && (in_pred_tgt != c_target)));
      end
      BR_JAL: begin
        c_taken   = 1'b1;
        c_mispred = !in_pred_tkn || (in_pred_tgt != c_target);
      end
      BR_JALR: begin
        c_taken   = 1'b1;
        c_target  = sum_rs1_imm & {{(XLEN-1){1'b1}}, 1'b0};
        c_mispred = !in_pred_tkn || (in_pred_tgt != c_target);
      end
      default: ;
    endcase
  end

  assign c_redirect = c_taken ? c_target : c_link;
  assign c_misalign = c_taken && c_target[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_taken    <= 1'b0;
      out_target   <= '0;
      out_link     <= '0;
      out_redirect <= '0;
      out_mispred  <= 1'b0;
      out_illegal  <= 1'b0;
      out_misalign <= 1'b0;
      r_idx        <= '0;
      r_trains     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= load;
      if (load) begin
        out_taken    <= c_taken;
        out_target   <= c_target;
        out_link     <= c_link;
        out_redirect <= c_redirect;
        out_mispred  <= c_mispred;
        out_illegal  <= c_illegal;
        out_misalign <= c_misalign;
        r_idx        <= in_pc[IDX_W+1:2];
        r_trains     <= c_trains;
      end
    end
  end

  // Train only when a legal conditional result actually leaves the stage.
  assign bht_upd_en = out_valid && out_ready && !flush && r_trains;

  assign unused_rd_pc_bits = ^{bht_rd_pc[XLEN-1:IDX_W+2], bht_rd_pc[1:0]};

  bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (bht_rd_pc[IDX_W+1:2]),
    .rd_tkn  (bht_rd_tkn),
    .upd_en  (bht_upd_en),
    .upd_idx (r_idx),
    .upd_tkn (out_taken)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model predicts each
// result and the BHT contents; a monitor checks results as they are consumed.
module tb_branch_resolve_unit;
  import riscy_pkg::*;

  localparam int XLEN        = 32;
  localparam int BHT_ENTRIES = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  br_op_e          in_op;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc, in_rs1, in_rs2, in_imm, in_pred_tgt;
  logic            in_pred_tkn;
  logic            out_valid, out_ready;
  logic            out_taken, out_mispred, out_illegal, out_misalign;
  logic [XLEN-1:0] out_target, out_link, out_redirect;
  logic [XLEN-1:0] bht_rd_pc;
  logic            bht_rd_tkn;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic [31:0] redirect;
    logic        mispred;
    logic        illegal;
    logic        misalign;
  } res_t;

  typedef struct packed {
    res_t        res;
    logic        trains;
    logic [31:0] pc;
  } sb_t;

  sb_t  expq[$];
  int   nVectors     = 0;
  int   nMiscompares = 0;
  int   bhtModel[BHT_ENTRIES];
  logic randReady    = 1'b0;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_pred_tkn(in_pred_tkn), .in_pred_tgt(in_pred_tgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link), .out_redirect(out_redirect),
    .out_mispred(out_mispred), .out_illegal(out_illegal),
    .out_misalign(out_misalign), .bht_rd_pc(bht_rd_pc), .bht_rd_tkn(bht_rd_tkn)
  );

  always #5 clk = ~clk;

  // Reference behaviour written from the architectural rules.
  function automatic res_t refModel(br_op_e op, logic [2:0] f3, logic [31:0] pc,
                                    logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                                    logic pt, logic [31:0] ptg);
    res_t   r;
    longint u1, u2;
    r      = '0;
    u1     = longint'({32'd0, rs1});
    u2     = longint'({32'd0, rs2});
    r.link = pc + 32'd4;
    case (op)
      BR_COND: begin
        r.target = pc + imm;
        case (f3)
          3'd0: r.taken = (rs1 == rs2);
          3'd1: r.taken = (rs1 != rs2);
          3'd4: r.taken = (int'(rs1) <  int'(rs2));
          3'd5: r.taken = (int'(rs1) >= int'(rs2));
          3'd6: r.taken = (u1 <  u2);
          3'd7: r.taken = (u1 >= u2);
          default: r.illegal = 1'b1;
        endcase
        if (!r.illegal)
          r.mispred = (r.taken != pt) || (r.taken && pt && ptg != r.target);
      end
      BR_JAL: begin
        r.target  = pc + imm;
        r.taken   = 1'b1;
        r.mispred = !pt || ptg != r.target;
      end
      BR_JALR: begin
        r.target  = (rs1 + imm) & 32'hFFFF_FFFE;
        r.taken   = 1'b1;
        r.mispred = !pt || ptg != r.target;
      end
      default: ;
    endcase
    r.redirect = r.taken ? r.target : r.link;
    r.misalign = r.taken && r.target[1];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input br_op_e op, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic pt, input logic [31:0] ptg);
    int   waited = 0;
    logic ok     = 1'b0;
    sb_t  e;
    in_valid = 1'b1; in_op = op; in_funct3 = f3; in_pc = pc;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pred_tkn = pt; in_pred_tgt = ptg;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) begin
        @(posedge clk); #1;
        waited++;
      end
    end
    if (!ok) begin
      checkOutput("accept_timeout", 128'(in_ready), 128'(1));
    end else if (op != BR_NONE) begin
      e.res    = refModel(op, f3, pc, rs1, rs2, imm, pt, ptg);
      e.trains = (op == BR_COND) && !e.res.illegal;
      e.pc     = pc;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    randReady = 1'b0;
    out_ready = 1'b1;
    while (expq.size() != 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    checkOutput("drain_empty", 128'(expq.size()), 128'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expq.delete();
    for (int i = 0; i < BHT_ENTRIES; i++) bhtModel[i] = 1;
    rst = 1'b0;
  endtask

  task automatic checkBht(input logic [31:0] pc);
    bht_rd_pc = pc;
    @(negedge clk);
    checkOutput("bht_rd_tkn", 128'(bht_rd_tkn), 128'(bhtModel[pc[5:2]] >= 2));
    @(posedge clk); #1;
  endtask

  // Monitor: every consumed result is compared and trains the BHT model.
  initial begin
    sb_t  e;
    res_t act;
    forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_result", 128'(out_valid), 128'(0));
        end else begin
          e   = expq.pop_front();
          act = {out_taken, out_target, out_link, out_redirect,
                 out_mispred, out_illegal, out_misalign};
          checkOutput("result", 128'(act), 128'(e.res));
          if (e.trains) begin
            if (e.res.taken) bhtModel[e.pc[5:2]] = (bhtModel[e.pc[5:2]] == 3) ? 3 : bhtModel[e.pc[5:2]] + 1;
            else             bhtModel[e.pc[5:2]] = (bhtModel[e.pc[5:2]] == 0) ? 0 : bhtModel[e.pc[5:2]] - 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t       hold;
    br_op_e     op;
    logic [2:0] f3;
    logic [31:0] pc, rs1, rs2, imm, ptg;
    logic       pt;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = BR_NONE; in_funct3 = 3'd0;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pred_tkn = 1'b0;
    in_pred_tgt = '0; out_ready = 1'b1; bht_rd_pc = '0;
    doReset();

    @(negedge clk);
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_outputs", 128'({out_taken, out_target, out_link, out_redirect,
                                       out_mispred, out_illegal, out_misalign}), 128'(0));
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    for (int i = 0; i < BHT_ENTRIES; i++) checkBht(32'(i) << 2);

    // BHT training: weak not-taken, then three taken, then one not-taken.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(BR_COND, F3_BEQ, 32'h40, 32'd5, 32'd5, 32'h10, 1'b0, 32'h0);
    drain();
    checkBht(32'h40);
    applyStimulus(BR_COND, F3_BNE, 32'h40, 32'd5, 32'd5, 32'h10, 1'b1, 32'h50);
    drain();
    checkBht(32'h40);
    doReset();
    checkBht(32'h40);

    // Directed resolution cases.
    applyStimulus(BR_COND, F3_BLT,  32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
    applyStimulus(BR_COND, F3_BLTU, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
    applyStimulus(BR_COND, F3_BEQ,  32'h100, 32'h1234, 32'h1234, 32'h20, 1'b1, 32'h120);
    applyStimulus(BR_JALR, 3'd0,    32'h40, 32'h2003, 32'd0, 32'h4, 1'b0, 32'h0);
    applyStimulus(BR_JAL,  3'd0,    32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 1'b1, 32'h10);
    applyStimulus(BR_COND, 3'd2,    32'h80, 32'd1, 32'd1, 32'h8, 1'b1, 32'h88);
    applyStimulus(BR_COND, 3'd3,    32'h80, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0);
    applyStimulus(BR_NONE, 3'd0,    32'h80, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0);
    drain();
    checkBht(32'h80);

    // Backpressure with a flush arriving while the result is held.
    out_ready = 1'b0;
    applyStimulus(BR_JAL, 3'd0, 32'h200, 32'd0, 32'd0, 32'h40, 1'b1, 32'h240);
    hold = expq[expq.size()-1].res;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (cyc == 2) flush = 1'b1;
      @(negedge clk);
      if (cyc < 3) begin
        checkOutput("hold_in_ready", 128'(in_ready), 128'(0));
        checkOutput("hold_out_valid", 128'(out_valid), 128'(1));
        checkOutput("hold_outputs", 128'({out_taken, out_target, out_link, out_redirect,
                                          out_mispred, out_illegal, out_misalign}), 128'(hold));
      end else begin
        checkOutput("flush_out_valid", 128'(out_valid), 128'(0));
        checkOutput("flush_in_ready", 128'(in_ready), 128'(1));
      end
      @(posedge clk); #1;
      if (cyc == 2) begin
        flush = 1'b0;
        void'(expq.pop_back());
      end
    end

    // An op presented together with flush is discarded.
    flush = 1'b1; in_valid = 1'b1; in_op = BR_JAL; in_pc = 32'h300; in_imm = 32'h8;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_discard", 128'(out_valid), 128'(0));
    @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    randReady = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op  = br_op_e'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      pc  = $urandom & 32'hFFFF_FFFC;
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFE) : ($urandom | 32'hFFFF_F000);
      pt  = 1'($urandom);
      ptg = ($urandom_range(0, 1) == 0) ? refModel(op, f3, pc, rs1, rs2, imm, 1'b1, 32'h0).target
                                        : $urandom;
      applyStimulus(op, f3, pc, rs1, rs2, imm, pt, ptg);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    for (int i = 0; i < BHT_ENTRIES; i++) checkBht(($urandom & 32'hFFFF_FFC0) | (32'(i) << 2) | 32'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
